// File: rtl/coin_credit_tracker.sv
// Coin-side credit accumulator for the vending FSM: accepts typed coins, tracks credit,
// and pays out change or refunds as a train of nickel pulses.
module coin_credit_tracker #(
  parameter int unsigned PRICE      = 25,
  parameter int unsigned MAX_CREDIT = 100,
  parameter int unsigned CREDIT_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                vend,
  input  logic                cancel,
  output logic                coin,
  output logic                sufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                busy,
  output logic [1:0]          state
);

  localparam int unsigned SUM_W  = CREDIT_W + 1;
  localparam int unsigned NICKEL = 5;

  typedef enum logic [1:0] {
    ACCUM = 2'b00,
    PULSE = 2'b01,
    GAP   = 2'b10,
    BAD   = 2'b11
  } state_t;

  state_t              st_q, st_d;
  logic [CREDIT_W-1:0] credit_d;
  logic                coin_d, reject_d;
  logic [CREDIT_W-1:0] coin_value;
  logic                coin_known;
  logic [SUM_W-1:0]    coin_sum;

  // Coin code decode
  always_comb begin
    coin_known = 1'b1;
    coin_value = '0;
    case (coin_type)
      2'b00:   coin_value = CREDIT_W'(5);
      2'b01:   coin_value = CREDIT_W'(10);
      2'b10:   coin_value = CREDIT_W'(25);
      default: coin_known = 1'b0;
    endcase
  end

  assign coin_sum     = SUM_W'(credit) + SUM_W'(coin_value);
  assign sufficient   = (credit >= CREDIT_W'(PRICE));
  assign change_pulse = (st_q == PULSE);
  assign busy         = (st_q != ACCUM);
  assign state        = st_q;

  // Next-state, credit and strobe logic; vend outranks cancel outranks coin
  always_comb begin
    st_d     = st_q;
    credit_d = credit;
    coin_d   = 1'b0;
    reject_d = 1'b0;
    case (st_q)
      ACCUM: begin
        if (vend && sufficient) begin
          credit_d = credit - CREDIT_W'(PRICE);
          st_d     = (credit_d != '0) ? PULSE : ACCUM;
          reject_d = coin_valid;
        end else if (cancel && (credit != '0)) begin
          st_d     = PULSE;
          reject_d = coin_valid;
        end else if (coin_valid) begin
          if (coin_known && (coin_sum <= SUM_W'(MAX_CREDIT))) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            coin_d   = 1'b1;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      PULSE: begin
        credit_d = credit - CREDIT_W'(NICKEL);
        st_d     = GAP;
        reject_d = coin_valid;
      end
      GAP: begin
        st_d     = (credit == '0) ? ACCUM : PULSE;
        reject_d = coin_valid;
      end
      default: begin
        st_d     = ACCUM;
        reject_d = coin_valid;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q        <= ACCUM;
      credit      <= '0;
      coin        <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      st_q        <= st_d;
      credit      <= credit_d;
      coin        <= coin_d;
      coin_reject <= reject_d;
    end
  end

endmodule

// File: tb/tb_coin_credit_tracker.sv
// Directed bench for coin_credit_tracker with hand-computed expectations.
module tb_coin_credit_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       vend;
  logic       cancel;
  logic       coin;
  logic       sufficient;
  logic [7:0] credit;
  logic       change_pulse;
  logic       coin_reject;
  logic       busy;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  coin_credit_tracker #(.PRICE(25), .MAX_CREDIT(100), .CREDIT_W(8)) dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin_type(coin_type),
    .vend(vend), .cancel(cancel), .coin(coin), .sufficient(sufficient),
    .credit(credit), .change_pulse(change_pulse), .coin_reject(coin_reject),
    .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One coin event, sampled at the next edge, strobe then dropped
  task automatic put(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    coin_valid = 1'b0;
  endtask

  // Count change pulses until ACCUM, bounded
  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < 200 && state != 2'b00; i++) begin
      n += int'(change_pulse);
      tick();
    end
  endtask

  int n;
  int pat;

  initial begin
    rst = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; vend = 1'b0; cancel = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_outs", {26'd0, coin, sufficient, change_pulse, coin_reject, busy, 1'b0}, 0);
    rst = 1'b0;

    // Coin sums
    put(2'b00);
    chk("nickel_coin", 32'(coin), 1);
    chk("nickel_credit", 32'(credit), 5);
    put(2'b01);
    chk("dime_coin_b2b", 32'(coin), 1);
    chk("credit15", 32'(credit), 15);
    chk("suff15", 32'(sufficient), 0);
    tick();
    chk("coin_drop", 32'(coin), 0);
    put(2'b01);
    chk("credit25", 32'(credit), 25);
    chk("suff25", 32'(sufficient), 1);

    // Vend with simultaneous coin at exact price
    vend = 1'b1; coin_valid = 1'b1; coin_type = 2'b10;
    tick();
    vend = 1'b0; coin_valid = 1'b0;
    chk("vendcoin_credit", 32'(credit), 0);
    chk("vendcoin_reject", 32'(coin_reject), 1);
    chk("vendcoin_nocoin", 32'(coin), 0);
    chk("vendcoin_state", 32'(state), 0);

    // Vend with 10 cents change
    put(2'b10);
    put(2'b01);
    chk("credit35", 32'(credit), 35);
    vend = 1'b1;
    tick();
    vend = 1'b0;
    chk("vend_credit", 32'(credit), 10);
    chk("vend_busy", 32'(busy), 1);
    pat = 0;
    for (int i = 0; i < 4; i++) begin
      pat = (pat << 1) | int'(change_pulse);
      tick();
    end
    chk("vend_pulse_pattern", 32'(pat), 32'b1010);
    chk("vend_back_accum", 32'(state), 0);
    chk("vend_credit0", 32'(credit), 0);

    // Invalid coin type
    put(2'b11);
    chk("bad_type_reject", 32'(coin_reject), 1);
    chk("bad_type_credit", 32'(credit), 0);

    // Overflow at 90
    put(2'b10); put(2'b10); put(2'b10); put(2'b01); put(2'b00);
    chk("credit90", 32'(credit), 90);
    put(2'b10);
    chk("ovf_reject", 32'(coin_reject), 1);
    chk("ovf_credit", 32'(credit), 90);
    chk("ovf_nocoin", 32'(coin), 0);

    // Cancel at 90, dime during PULSE
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_state", 32'(state), 1);
    chk("cancel_credit", 32'(credit), 90);
    n = int'(change_pulse);
    put(2'b01);
    chk("pulse_dime_reject", 32'(coin_reject), 1);
    chk("pulse_dime_credit", 32'(credit), 85);
    chk("pulse_dime_gap", 32'(state), 2);
    begin
      int rest;
      drain(rest);
      n += rest;
    end
    chk("refund90_pulses", 32'(n), 18);
    chk("refund90_state", 32'(state), 0);
    chk("refund90_credit", 32'(credit), 0);

    // Cancel at 20
    put(2'b01); put(2'b01);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    drain(n);
    chk("refund20_pulses", 32'(n), 4);
    chk("refund20_credit", 32'(credit), 0);

    // Vend below price ignored, and does not block cancel
    put(2'b01); put(2'b01);
    vend = 1'b1;
    tick();
    vend = 1'b0;
    chk("lowvend_credit", 32'(credit), 20);
    chk("lowvend_state", 32'(state), 0);
    vend = 1'b1; cancel = 1'b1;
    tick();
    vend = 1'b0; cancel = 1'b0;
    chk("lowvend_cancel_state", 32'(state), 1);

    // Reset during second PULSE of a 20-cent refund
    tick();
    tick();
    chk("second_pulse", 32'(change_pulse), 1);
    chk("second_pulse_credit", 32'(credit), 15);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_credit", 32'(credit), 0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      n += int'(change_pulse);
      tick();
    end
    chk("midrst_no_pulses", 32'(n), 0);

    // Cancel with zero credit ignored
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel0_state", 32'(state), 0);
    chk("cancel0_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_credit_tracker.md
# coin_credit_tracker

Credit accumulator and change dispenser on the coin side of the vending FSM. Accepts typed coin events, keeps the running credit, and drives the FSM's `coin` and `sufficient` inputs. On a vend acknowledgement it deducts the price and pays out the remainder as nickel pulses; on a cancel it refunds the full credit the same way.

## Interface
- PRICE, 25: item price in cents; multiple of 5, ≤ MAX_CREDIT
- MAX_CREDIT, 100: highest credit the block holds; multiple of 5
- CREDIT_W, 8: credit width; must hold MAX_CREDIT + 25

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle coin-inserted strobe
- coin_type  in  2  coin code: 00 = nickel (5), 01 = dime (10), 10 = quarter (25), 11 = invalid
- vend  in  1  vend acknowledge from the FSM; one-cycle strobe
- cancel  in  1  refund request; one-cycle strobe
- coin  out  1  one-cycle pulse to the FSM per accepted coin
- sufficient  out  1  credit ≥ PRICE; combinational from the credit register
- credit  out  CREDIT_W  current credit in cents
- change_pulse  out  1  one cycle high per nickel returned
- coin_reject  out  1  one-cycle pulse per refused coin event
- busy  out  1  high while a refund is in progress
- state  out  2  00 ACCUM, 01 PULSE, 10 GAP; 11 unused

## Operation
- Reset values: state ACCUM, credit 0, coin 0, sufficient 0, change_pulse 0, coin_reject 0, busy 0.
- ACCUM, priority vend > cancel > coin_valid:
  - vend with sufficient: credit ← credit − PRICE; go to PULSE if the result is nonzero, else stay in ACCUM.
  - vend without sufficient: ignored, no state or credit change.
  - cancel with credit > 0: go to PULSE, credit unchanged. cancel with credit 0 is ignored.
  - coin_valid alone with a valid type and credit + value ≤ MAX_CREDIT: credit ← credit + value, pulse coin.
  - coin_valid with type 11, or an overflowing sum: pulse coin_reject, credit unchanged.
  - coin_valid in the same cycle as an accepted vend or cancel: refused, pulse coin_reject.
  - Precedence is decided by which of vend or cancel is actually taken that cycle. An ignored vend does not block cancel or coin_valid.
- PULSE: change_pulse = 1 and busy = 1 (Moore outputs). At the edge: credit ← credit − 5, go to GAP.
- GAP: change_pulse = 0, busy = 1. At the edge: go to ACCUM if credit = 0, else go to PULSE.
- During PULSE and GAP:
  - every coin_valid is refused with coin_reject;
  - vend and cancel are ignored.
- Credit is always a multiple of 5, so a refund never underflows. Payout uses nickels only: R cents produce R/5 pulses.
- State 11 is unreachable; if it is entered, recover to ACCUM on the next edge with credit unchanged.
- Reset mid-refund: takes effect at the next edge; refund aborted, credit cleared, no further change_pulse.

## Timing
- Coin accept: coin_valid sampled at edge N. At edge N, credit updates and coin/coin_reject register high; they stay high for the cycle after edge N and drop at N+1.
- sufficient tracks credit with zero added latency (same cycle as the credit update).
- Vend with refund: vend sampled at edge N, state PULSE after N. change_pulse is high for cycles N..N+1, N+2..N+3, … alternating with GAP cycles. Return to ACCUM at edge N+2k for k nickels.
- busy equals (state ≠ ACCUM).
- Back-to-back coin_valid on consecutive cycles are each accepted independently; there is no throughput limit in ACCUM.

## Test plan
- Reset: rst = 1 for 2 cycles → state 00, credit 0, every output 0.
- Coin sums with PRICE = 25:
  - nickel + dime → credit 15, sufficient 0;
  - then a dime → credit 25, sufficient 1;
  - exactly one coin pulse per accepted coin, each one cycle after its coin_valid.
- Vend with change:
  - quarter + dime (35), then vend → credit 10 after vend, exactly 2 change_pulse cycles separated by one GAP cycle;
  - return to ACCUM with credit 0 four cycles after the vend edge.
- Rejects:
  - coin_type 11 → coin_reject, credit unchanged;
  - credit 90 plus a quarter → coin_reject, credit stays 90;
  - a dime during PULSE → coin_reject, refund unaffected.
- Cancel and priority:
  - credit 20, cancel → 4 change_pulse, credit 0;
  - vend and coin_valid in the same cycle at credit 25 → vend taken, credit 0, coin_reject, no coin pulse;
  - vend at credit 20 → ignored, credit stays 20.
- Reset mid-refund: rst asserted in the second PULSE of a 20-cent refund → credit 0, ACCUM, no further change_pulse.
